// File: rtl/tu_pkg.sv
// Shared types and helpers for the test-unit sequencer family.
package tu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    FAIL
  } tu_state_e;

  function automatic int tu_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tu_seq_if.sv
// Upstream/downstream token and step handshake bundle of one test unit.
interface tu_seq_if #(
  parameter int NUM_STEPS = 4,
  parameter int CNT_W     = 8
);
  import tu_pkg::*;
  localparam int IW = tu_idx_w(NUM_STEPS);

  logic             from_up_pass;
  logic             to_down_pass;
  logic             step_start;
  logic [IW-1:0]    step_idx;
  logic             step_done;
  logic             step_ok;
  logic             busy;
  logic [CNT_W-1:0] fail_cnt;
  logic             timeout_err;

  modport master (
    output from_up_pass, step_done, step_ok,
    input  to_down_pass, step_start, step_idx, busy, fail_cnt, timeout_err
  );

  modport slave (
    input  from_up_pass, step_done, step_ok,
    output to_down_pass, step_start, step_idx, busy, fail_cnt, timeout_err
  );
endinterface

// File: rtl/tu_step_timer.sv
// Per-step watchdog: counts enabled cycles from a clear, flags the last allowed one.
module tu_step_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + TW'(1);
  end

  // Combinational so the step can still be closed out in the cycle the count hits LAST.
  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/tu_seq.sv
// Chained self-test sequencer: runs NUM_STEPS steps under a watchdog, passes the token on success.
module tu_seq
  import tu_pkg::*;
#(
  parameter int NUM_STEPS    = 4,
  parameter int TIMEOUT      = 1024,
  parameter int STOP_ON_FAIL = 1,
  parameter int CNT_W        = 8
) (
  input  logic     clock,
  input  logic     rst,
  tu_seq_if.slave  bus
);
  localparam int            IW       = tu_idx_w(NUM_STEPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STEPS - 1);

  tu_state_e        state_q, state_d;
  logic             up_q;
  logic             rec_fail_q, rec_fail_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             start_q, busy_q, pass_q;
  logic             tmr_exp;

  tu_step_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .rst     (rst),
    .clr     (state_q == ISSUE),
    .en      (state_q == WAIT),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    rec_fail_d = rec_fail_q;
    // Losing the upstream token freezes everything for readout.
    if (state_q != IDLE && !bus.from_up_pass) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.from_up_pass && !up_q) begin
          idx_d   = '0;
          cnt_d   = '0;
          terr_d  = 1'b0;
          state_d = ISSUE;
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (bus.step_done) begin
            rec_fail_d = !bus.step_ok;
            state_d    = NEXT;
          end else if (tmr_exp) begin
            rec_fail_d = 1'b1;
            terr_d     = 1'b1;
            state_d    = NEXT;
          end
        end
        NEXT: begin
          if (rec_fail_q && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (rec_fail_q && STOP_ON_FAIL != 0) begin
            state_d = FAIL;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ISSUE;
          end
        end
        DONE, FAIL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      up_q       <= 1'b0;
      rec_fail_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      terr_q     <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_q       <= bus.from_up_pass;
      rec_fail_q <= rec_fail_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
      start_q    <= (state_d == ISSUE);
      busy_q     <= (state_d == ISSUE) || (state_d == WAIT) || (state_d == NEXT);
      pass_q     <= (state_d == DONE) && (cnt_d == '0);
    end
  end

  assign bus.step_start   = start_q;
  assign bus.step_idx     = idx_q;
  assign bus.busy         = busy_q;
  assign bus.fail_cnt     = cnt_q;
  assign bus.timeout_err  = terr_q;
  assign bus.to_down_pass = pass_q;
endmodule

// File: tb/tb_tu_seq.sv
// Directed bench for tu_seq: unit A runs all steps, unit B halts on first failure.
module tb_tu_seq;
  import tu_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  tu_seq_if #(.NUM_STEPS(4), .CNT_W(8)) ifa ();
  tu_seq_if #(.NUM_STEPS(4), .CNT_W(8)) ifb ();

  tu_seq #(.NUM_STEPS(4), .TIMEOUT(16), .STOP_ON_FAIL(0), .CNT_W(8)) u_a (
    .clock(clock), .rst(rst), .bus(ifa));
  tu_seq #(.NUM_STEPS(4), .TIMEOUT(16), .STOP_ON_FAIL(1), .CNT_W(8)) u_b (
    .clock(clock), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  // Responder config: step done arrives dly cycles after the step_start cycle (0 = never).
  int dly [2][4];
  bit okc [2][4];
  int pend[2];
  bit okv [2];
  bit stray[2];
  int n_st[2];
  int st_idx[2][16];
  int st_cyc[2][16];

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] st;
    int ix[2];
    bit dn[2];
    @(negedge clock);
    cyc++;
    st    = {ifb.step_start, ifa.step_start};
    ix[0] = int'(ifa.step_idx);
    ix[1] = int'(ifb.step_idx);
    for (int u = 0; u < 2; u++) begin
      dn[u] = stray[u];
      if (pend[u] > 0) begin
        pend[u]--;
        if (pend[u] == 0) dn[u] = 1'b1;
      end
      if (st[u]) begin
        if (n_st[u] < 16) begin
          st_idx[u][n_st[u]] = ix[u];
          st_cyc[u][n_st[u]] = cyc;
        end
        n_st[u]++;
        pend[u] = dly[u][ix[u]];
        okv[u]  = okc[u][ix[u]];
      end
    end
    ifa.step_done = dn[0];
    ifa.step_ok   = okv[0];
    ifb.step_done = dn[1];
    ifb.step_ok   = okv[1];
  endtask

  function automatic int sig(input int u, input int which);
    if (which == 0) return (u == 0) ? int'(ifa.to_down_pass) : int'(ifb.to_down_pass);
    return (u == 0) ? int'(ifa.busy) : int'(ifb.busy);
  endfunction

  task automatic clr_log(input int u);
    n_st[u] = 0;
    pend[u] = 0;
  endtask

  task automatic wait_starts(input int u, input int n, input string tag);
    int b = 0;
    while (n_st[u] < n && b < 300) begin tick(); b++; end
    if (n_st[u] < n) chk(tag, n_st[u], n);
  endtask

  // which: 0 = to_down_pass, 1 = busy
  task automatic wait_sig(input int u, input int which, input int val, input string tag,
                          output int at);
    int b = 0;
    while (sig(u, which) != val && b < 300) begin tick(); b++; end
    at = cyc;
    if (sig(u, which) != val) chk(tag, sig(u, which), val);
  endtask

  initial begin
    int t0, tdp;
    ifa.from_up_pass = 0; ifa.step_done = 0; ifa.step_ok = 0;
    ifb.from_up_pass = 0; ifb.step_done = 0; ifb.step_ok = 0;
    for (int u = 0; u < 2; u++) begin
      clr_log(u); stray[u] = 0; okv[u] = 0;
      for (int i = 0; i < 4; i++) begin dly[u][i] = 5; okc[u][i] = 1; end
    end

    // Reset state
    repeat (3) tick();
    chk("rst_pass",  ifa.to_down_pass, 0);
    chk("rst_start", ifa.step_start, 0);
    chk("rst_busy",  ifa.busy, 0);
    chk("rst_terr",  ifa.timeout_err, 0);
    chk("rst_idx",   ifa.step_idx, 0);
    chk("rst_fcnt",  ifa.fail_cnt, 0);
    rst = 0;
    repeat (2) tick();

    // All four steps pass, 5-cycle response
    clr_log(0);
    ifa.from_up_pass = 1; t0 = cyc;
    wait_starts(0, 4, "p_starts_to");
    wait_sig(0, 0, 1, "p_pass_to", tdp);
    chk("p_first_lat", st_cyc[0][0], t0 + 1);
    for (int i = 0; i < 4; i++) chk($sformatf("p_idx%0d", i), st_idx[0][i], i);
    chk("p_step_gap",  st_cyc[0][1] - st_cyc[0][0], 7);
    chk("p_pass_lat",  tdp, st_cyc[0][3] + 7);
    chk("p_fcnt",      ifa.fail_cnt, 0);
    chk("p_terr",      ifa.timeout_err, 0);
    chk("p_busy",      ifa.busy, 0);
    chk("p_idx_hold",  ifa.step_idx, 3);
    ifa.from_up_pass = 0;
    tick();
    chk("p_abort_pass", ifa.to_down_pass, 0);
    chk("p_abort_idx",  ifa.step_idx, 3);
    tick();

    // Step 2 never answers: timeout, later steps still run
    clr_log(0);
    dly[0] = '{5, 5, 0, 5};
    ifa.from_up_pass = 1;
    wait_starts(0, 4, "t_starts_to");
    wait_sig(0, 1, 0, "t_idle_to", tdp);
    chk("t_gap",   st_cyc[0][3] - st_cyc[0][2], 18);
    chk("t_fcnt",  ifa.fail_cnt, 1);
    chk("t_terr",  ifa.timeout_err, 1);
    chk("t_pass",  ifa.to_down_pass, 0);
    chk("t_idx",   ifa.step_idx, 3);
    ifa.from_up_pass = 0;
    repeat (2) tick();

    // Done in the very cycle the timer expires: done wins
    clr_log(0);
    dly[0] = '{5, 16, 5, 5};
    ifa.from_up_pass = 1;
    wait_starts(0, 4, "e_starts_to");
    wait_sig(0, 0, 1, "e_pass_to", tdp);
    chk("e_gap",   st_cyc[0][2] - st_cyc[0][1], 18);
    chk("e_terr",  ifa.timeout_err, 0);
    chk("e_fcnt",  ifa.fail_cnt, 0);
    chk("e_pass",  ifa.to_down_pass, 1);
    ifa.from_up_pass = 0;
    repeat (2) tick();

    // Abort during step 2, counters held, then a fresh run
    clr_log(0);
    dly[0] = '{5, 5, 0, 5};
    okc[0] = '{1, 0, 1, 1};
    ifa.from_up_pass = 1;
    wait_starts(0, 3, "a_starts_to");
    repeat (4) tick();
    chk("a_busy_pre", ifa.busy, 1);
    ifa.from_up_pass = 0;
    tick();
    chk("a_busy",  ifa.busy, 0);
    chk("a_fcnt",  ifa.fail_cnt, 1);
    chk("a_idx",   ifa.step_idx, 2);
    repeat (3) tick();
    chk("a_fcnt_hold", ifa.fail_cnt, 1);
    clr_log(0);
    dly[0] = '{5, 5, 5, 5};
    okc[0] = '{1, 1, 1, 1};
    ifa.from_up_pass = 1;
    tick();
    chk("a_re_start", ifa.step_start, 1);
    chk("a_re_idx",   ifa.step_idx, 0);
    chk("a_re_fcnt",  ifa.fail_cnt, 0);
    wait_sig(0, 0, 1, "a_re_pass_to", tdp);
    chk("a_re_steps", n_st[0], 4);
    ifa.from_up_pass = 0;
    repeat (2) tick();

    // Unit B halts on first failure
    clr_log(1);
    okc[1] = '{1, 0, 1, 1};
    ifb.from_up_pass = 1;
    wait_starts(1, 2, "s_starts_to");
    repeat (30) tick();
    chk("s_steps", n_st[1], 2);
    chk("s_fcnt",  ifb.fail_cnt, 1);
    chk("s_pass",  ifb.to_down_pass, 0);
    chk("s_busy",  ifb.busy, 0);
    chk("s_idx",   ifb.step_idx, 1);
    chk("s_terr",  ifb.timeout_err, 0);
    ifb.from_up_pass = 0;
    repeat (2) tick();

    // Async reset mid-WAIT after a timed-out step
    clr_log(0);
    dly[0] = '{0, 0, 5, 5};
    ifa.from_up_pass = 1;
    wait_starts(0, 2, "r_starts_to");
    repeat (3) tick();
    chk("r_pre_terr", ifa.timeout_err, 1);
    chk("r_pre_idx",  ifa.step_idx, 1);
    #1 rst = 1;
    #1;
    chk("r_busy",  ifa.busy, 0);
    chk("r_fcnt",  ifa.fail_cnt, 0);
    chk("r_terr",  ifa.timeout_err, 0);
    chk("r_idx",   ifa.step_idx, 0);
    ifa.from_up_pass = 0;
    tick();
    rst = 0;
    pend[0] = 0;
    tick();
    stray[0] = 1;
    tick();
    stray[0] = 0;
    repeat (3) tick();
    chk("r_stray_busy",  ifa.busy, 0);
    chk("r_stray_fcnt",  ifa.fail_cnt, 0);
    chk("r_stray_steps", n_st[0], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
